// File: rtl/multi_cycle_datapath.sv
// Multi-cycle 32-bit MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT over a single memory port.
// Optional bne (opcode 0x05) is compiled in with `define MULTI_CYCLE_DATAPATH_BNE_EN.
module multi_cycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_AW   = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              halted,
  output logic [2:0]        dbg_state
);

  // Memory handshake: while mem_req=1 the request fields stay stable; the transfer
  // completes on the rising edge where mem_ready=1. mem_ready is ignored when mem_req=0.

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t      r_state;
  state_t      w_next_state;
  state_t      w_exec_next;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu;
  logic [31:0] r_regs [0:31];

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [31:0] w_imm_se;
  logic [31:0] w_ea;
  logic [31:0] w_alu;
  logic        w_taken;
  logic        w_jump;
  logic [4:0]  w_wb_dst;
  logic [31:0] w_addr32;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_funct  = r_ir[5:0];
  assign w_imm_se = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_ea     = r_a + w_imm_se;
  assign w_wb_dst = (w_op == OP_RTYPE) ? w_rd : w_rt;

  // Execute decode: result, branch/jump intent and the state that follows EXEC.
  always_comb begin
    w_alu       = 32'd0;
    w_taken     = 1'b0;
    w_jump      = 1'b0;
    w_exec_next = S_HALT;
    case (w_op)
      OP_RTYPE: begin
        w_exec_next = S_WB;
        case (w_funct)
          6'h20:   w_alu = r_a + r_b;
          6'h22:   w_alu = r_a - r_b;
          6'h24:   w_alu = r_a & r_b;
          6'h25:   w_alu = r_a | r_b;
          6'h2A:   w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
          default: w_exec_next = S_HALT;
        endcase
      end
      OP_ADDI: begin
        w_alu       = w_ea;
        w_exec_next = S_WB;
      end
      OP_LW, OP_SW: begin
        w_alu       = w_ea;
        w_exec_next = (w_ea[1:0] == 2'b00) ? S_MEM : S_HALT;
      end
      OP_BEQ: begin
        w_taken     = (r_a == r_b);
        w_exec_next = S_FETCH;
      end
`ifdef MULTI_CYCLE_DATAPATH_BNE_EN
      OP_BNE: begin
        w_taken     = (r_a != r_b);
        w_exec_next = S_FETCH;
      end
`else
      OP_BNE: w_exec_next = S_HALT;
`endif
      OP_J: begin
        w_jump      = 1'b1;
        w_exec_next = S_FETCH;
      end
      default: w_exec_next = S_HALT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC:   w_next_state = w_exec_next;
      S_MEM:    if (mem_ready) w_next_state = (w_op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_HALT;
    endcase
  end

  // Bus outputs are decoded from state; gating with reset drops them without a clock edge.
  assign w_addr32  = (r_state == S_FETCH) ? r_pc : ((r_state == S_MEM) ? r_alu : 32'd0);
  assign mem_req   = !reset && ((r_state == S_FETCH) || (r_state == S_MEM));
  assign mem_we    = !reset && (r_state == S_MEM) && (w_op == OP_SW);
  assign mem_addr  = reset ? '0 : w_addr32[MEM_AW-1:0];
  assign mem_wdata = mem_we ? r_b : 32'd0;
  assign pc        = r_pc;
  assign halted    = (r_state == S_HALT);
  assign dbg_state = r_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_ir  <= 32'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_alu <= 32'd0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + 32'd4;
          end
        end
        S_DECODE: begin
          r_a <= (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
          r_b <= (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];
        end
        S_EXEC: begin
          // r_pc already points past the branch, so the offset is relative to pc+4.
          r_alu <= w_alu;
          if (w_taken) r_pc <= r_pc + {w_imm_se[29:0], 2'b00};
          if (w_jump)  r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        end
        S_MEM: begin
          if (mem_ready && (w_op == OP_LW)) r_alu <= mem_rdata;
        end
        S_WB: begin
          if (w_wb_dst != 5'd0) r_regs[w_wb_dst] <= r_alu;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_datapath.sv
// Directed bench for multi_cycle_datapath: instruction table with exact cycle budgets,
// then hand-written sequences for wait states, branches, halts, bne and async reset.
module tb_multi_cycle_datapath;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc;
  logic        halted;
  logic [2:0]  dbg_state;

  logic [31:0] mem [0:63];
  int          wait_cfg;
  int          wait_cnt;
  int          total;
  int          passed;

  multi_cycle_datapath #(.RESET_PC(32'h0000_0000), .MEM_AW(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .halted    (halted),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory responder: ready after wait_cfg extra cycles, write on the completing edge
  assign mem_rdata = mem[mem_addr[7:2]];
  initial begin
    mem_ready = 1'b0;
    wait_cnt  = 0;
  end
  always begin
    @(negedge clock);
    if (mem_req) begin
      mem_ready = (wait_cnt >= wait_cfg);
      wait_cnt++;
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end
    @(posedge clock);
    if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
      wait_cnt = 0;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          cycles;
    logic [31:0] exp_pc;
    int          reg_idx;
    logic [31:0] reg_val;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int tgt);
    return {6'h02, tgt[25:0]};
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    wait_cfg = 0;
    reset    = 1'b1;
    clear_mem();

    #2;
    check("reset_pc",    pc,        32'h0);
    check("reset_req",   {31'd0, mem_req}, 32'd0);
    check("reset_halt",  {31'd0, halted},  32'd0);
    check("reset_addr",  mem_addr,  32'h0);
    check("reset_wdata", mem_wdata, 32'h0);

    // ---------- table-driven program, zero-wait memory ----------
    vecs[0]  = '{32'd0,  enc_i(8, 0, 1, 5),          4, 32'd4,  1,  32'd5};
    vecs[1]  = '{32'd4,  enc_i(8, 0, 2, 7),          4, 32'd8,  2,  32'd7};
    vecs[2]  = '{32'd8,  enc_r(1, 2, 3, 'h20),       4, 32'd12, 3,  32'd12};
    vecs[3]  = '{32'd12, enc_r(1, 2, 5, 'h22),       4, 32'd16, 5,  32'hFFFF_FFFE};
    vecs[4]  = '{32'd16, enc_r(1, 2, 6, 'h24),       4, 32'd20, 6,  32'd5};
    vecs[5]  = '{32'd20, enc_r(1, 2, 7, 'h25),       4, 32'd24, 7,  32'd7};
    vecs[6]  = '{32'd24, enc_r(5, 1, 8, 'h2A),       4, 32'd28, 8,  32'd1};
    vecs[7]  = '{32'd28, enc_i('h2B, 0, 3, 'h80),    4, 32'd32, 3,  32'd12};
    vecs[8]  = '{32'd32, enc_i('h23, 0, 4, 'h80),    5, 32'd36, 4,  32'd12};
    vecs[9]  = '{32'd36, enc_i(8, 0, 9, 'hFFFF),     4, 32'd40, 9,  32'hFFFF_FFFF};
    vecs[10] = '{32'd40, enc_i(8, 9, 10, 3),         4, 32'd44, 10, 32'd2};
    vecs[11] = '{32'd44, enc_r(1, 2, 0, 'h22),       4, 32'd48, 0,  32'd0};
    vecs[12] = '{32'd48, enc_i(4, 1, 2, 5),          3, 32'd52, 1,  32'd5};
    vecs[13] = '{32'd52, enc_i(4, 1, 1, 2),          3, 32'd64, 1,  32'd5};
    vecs[14] = '{32'd64, enc_j(18),                  3, 32'd72, 2,  32'd7};
    vecs[15] = '{32'd72, enc_r(5, 9, 11, 'h2A),      4, 32'd76, 11, 32'd1};
    for (int i = 0; i < 16; i++) mem[vecs[i].addr[7:2]] = vecs[i].instr;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run(vecs[i].cycles);
      check($sformatf("vec%0d_pc", i),    pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_reg", i),   dut.r_regs[vecs[i].reg_idx], vecs[i].reg_val);
      check($sformatf("vec%0d_state", i), {29'd0, dbg_state}, 32'd0);
    end
    check("sw_mem_word", mem[32], 32'd12);

    // ---------- sw/lw with 3 wait cycles ----------
    clear_mem();
    wait_cfg = 3;
    mem[0]  = enc_i(8, 0, 3, 12);
    mem[1]  = enc_j(16);
    mem[16] = enc_i('h2B, 0, 3, 8);
    mem[17] = enc_i('h23, 0, 4, 8);
    do_reset();
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        @(negedge clock);
        if (mem_req && mem_we) break;
      end
      check("sw_found", {31'd0, k < 100}, 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sw_req_c%0d", k),   {31'd0, mem_req}, 32'd1);
      check($sformatf("sw_addr_c%0d", k),  mem_addr,  32'd8);
      check($sformatf("sw_wdata_c%0d", k), mem_wdata, 32'd12);
      @(negedge clock);
    end
    check("sw_then_fetch_addr", mem_addr, 32'h44);
    check("sw_wait_mem_word",   mem[2],   32'd12);
    for (int k = 0; k < 60 && dut.r_regs[4] != 32'd12; k++) @(negedge clock);
    check("lw_wait_r4", dut.r_regs[4], 32'd12);

    // ---------- beq to itself at 0x20 ----------
    clear_mem();
    wait_cfg = 0;
    mem[0] = enc_j(8);
    mem[8] = enc_i(4, 1, 1, 'hFFFF);
    do_reset();
    run(3);
    check("j_pc", pc, 32'h20);
    run(3);
    check("beq_self_addr", mem_addr, 32'h20);
    check("beq_self_req",  {31'd0, mem_req}, 32'd1);
    run(3);
    check("beq_self_pc2", pc, 32'h20);

    // ---------- illegal opcode 0x3F ----------
    clear_mem();
    mem[0] = 32'hFC00_0000;
    do_reset();
    run(3);
    check("ill_halted", {31'd0, halted},  32'd1);
    check("ill_req",    {31'd0, mem_req}, 32'd0);
    check("ill_pc",     pc, 32'd4);
    run(5);
    check("ill_pc_frozen", pc, 32'd4);
    check("ill_req_hold",  {31'd0, mem_req}, 32'd0);

    // ---------- unaligned lw at 0x6 ----------
    clear_mem();
    mem[0] = enc_i(8, 0, 1, 6);
    mem[1] = enc_i('h23, 1, 2, 0);
    do_reset();
    run(7);
    check("unal_halted", {31'd0, halted},  32'd1);
    check("unal_req",    {31'd0, mem_req}, 32'd0);
    check("unal_pc",     pc, 32'd8);
    run(5);
    check("unal_pc_frozen", pc, 32'd8);
    check("unal_no_wb",     dut.r_regs[2], 32'd0);

    // ---------- bne $1,$0 with $1=1 ----------
    clear_mem();
    mem[0] = enc_i(8, 0, 1, 1);
    mem[1] = enc_i(5, 1, 0, 3);
    do_reset();
    run(7);
`ifdef MULTI_CYCLE_DATAPATH_BNE_EN
    check("bne_pc",     pc, 32'd20);
    check("bne_halted", {31'd0, halted}, 32'd0);
`else
    check("bne_pc",     pc, 32'd8);
    check("bne_halted", {31'd0, halted}, 32'd1);
`endif

    // ---------- async reset while a fetch waits ----------
    clear_mem();
    mem[0] = enc_i(8, 0, 1, 5);
    mem[1] = enc_i(8, 0, 2, 7);
    do_reset();
    repeat (4) @(posedge clock);
    #1 wait_cfg = 20;
    repeat (2) @(negedge clock);
    #2;
    check("pre_rst_pc",  pc, 32'd4);
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    check("pre_rst_r1",  dut.r_regs[1], 32'd5);
    reset = 1'b1;
    #1;
    check("rst_req",   {31'd0, mem_req}, 32'd0);
    check("rst_pc",    pc, 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_r1",    dut.r_regs[1], 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    wait_cfg = 0;
    #1;
    check("post_rst_req",  {31'd0, mem_req}, 32'd1);
    check("post_rst_addr", mem_addr, 32'd0);
    run(4);
    check("post_rst_pc", pc, 32'd4);
    check("post_rst_r1", dut.r_regs[1], 32'd5);

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
